// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: state encoding,
// M-extension funct3 values, ALU control codes and the iteration count.
package muldiv_pkg;

  localparam int unsigned NumIter = 32;

  typedef enum logic [2:0] {
    StIdle,
    StNegA,
    StNegB,
    StMulStep,
    StDivCmp,
    StDivSub,
    StFixSign,
    StDone
  } state_e;

  localparam logic [2:0] F3Mul  = 3'b000;
  localparam logic [2:0] F3Div  = 3'b100;
  localparam logic [2:0] F3Divu = 3'b101;
  localparam logic [2:0] F3Rem  = 3'b110;
  localparam logic [2:0] F3Remu = 3'b111;

  localparam logic [5:0] ALU_CTRL_ADD  = 6'b000000;
  localparam logic [5:0] ALU_CTRL_SUB  = 6'b001000;
  localparam logic [5:0] ALU_CTRL_SLTU = 6'b000011;

  // MUL plus the four divide/remainder codes (all have funct3[2] set).
  function automatic logic f3_supported(input logic [2:0] f3);
    return (f3 == F3Mul) || f3[2];
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M MUL/DIV/DIVU/REM/REMU controller that borrows the
// execute-stage ALU. Shift-add multiply, restoring divide.
// Optional build macro: MULDIV_MUL_EARLY_EXIT_EN ends MUL once the remaining
// multiplier bits are all zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [5:0]      alu_control,
  output logic [XLEN-1:0] alu_op_a,
  output logic [XLEN-1:0] alu_op_b,
  input  logic [XLEN-1:0] alu_result
);

  state_e state_q, state_d;
  // a: multiplicand / dividend-then-quotient; b: multiplier / divisor;
  // acc: product accumulator / partial remainder.
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [2:0]      f3_q, f3_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            ge_q, ge_d, sa_q, sa_d, sb_q, sb_d;

  logic [XLEN-1:0] rprime, fix_val;
  logic            ge, neg, last;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      f3_q     <= '0;
      cnt_q    <= '0;
      ge_q     <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      f3_q     <= f3_d;
      cnt_q    <= cnt_d;
      ge_q     <= ge_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
    end
  end

  // Next-state, datapath updates and ALU drives.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    f3_d        = f3_q;
    cnt_d       = cnt_q;
    ge_d        = ge_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    alu_control = ALU_CTRL_ADD;
    alu_op_a    = '0;
    alu_op_b    = '0;
    rprime      = '0;
    fix_val     = '0;
    ge          = 1'b0;
    neg         = 1'b0;
    last        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          f3_d  = funct3;
          a_d   = rs1;
          b_d   = rs2;
          acc_d = '0;
          cnt_d = '0;
          ge_d  = 1'b0;
          sa_d  = rs1[XLEN-1];
          sb_d  = rs2[XLEN-1];
          if (!f3_supported(funct3)) begin
            state_d  = StDone;
            result_d = '0;
          end else if (funct3[2] && (rs2 == '0)) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            state_d  = StDone;
            result_d = funct3[1] ? rs1 : '1;
`ifdef MULDIV_MUL_EARLY_EXIT_EN
          end else if ((funct3 == F3Mul) && (rs2 == '0)) begin
            state_d  = StDone;
            result_d = '0;
`endif
          end else if (funct3 == F3Mul) begin
            state_d = StMulStep;
          end else if (funct3[0]) begin
            state_d = StDivCmp;
          end else begin
            state_d = StNegA;
          end
        end
      end

      StNegA: begin
        alu_control = ALU_CTRL_SUB;
        alu_op_b    = a_q;
        if (a_q[XLEN-1]) a_d = alu_result;
        state_d = StNegB;
      end

      StNegB: begin
        alu_control = ALU_CTRL_SUB;
        alu_op_b    = b_q;
        if (b_q[XLEN-1]) b_d = alu_result;
        state_d = StDivCmp;
      end

      StMulStep: begin
        alu_control = ALU_CTRL_ADD;
        alu_op_a    = acc_q;
        alu_op_b    = a_q;
        if (b_q[0]) acc_d = alu_result;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 6'd1;
        last  = (cnt_q == 6'(NumIter - 1));
`ifdef MULDIV_MUL_EARLY_EXIT_EN
        last  = last || ((b_q >> 1) == '0);
`endif
        if (last) begin
          state_d  = StDone;
          result_d = acc_d;
        end
      end

      StDivCmp: begin
        // Shift one dividend bit into the remainder; rem[31] is the implied
        // 33rd bit, so when set the shifted value always exceeds the divisor.
        rprime      = {acc_q[XLEN-2:0], a_q[XLEN-1]};
        alu_control = ALU_CTRL_SLTU;
        alu_op_a    = rprime;
        alu_op_b    = b_q;
        ge          = acc_q[XLEN-1] | ~alu_result[0];
        acc_d       = rprime;
        a_d         = {a_q[XLEN-2:0], ge};
        ge_d        = ge;
        state_d     = StDivSub;
      end

      StDivSub: begin
        alu_control = ALU_CTRL_SUB;
        alu_op_a    = acc_q;
        alu_op_b    = b_q;
        if (ge_q) acc_d = alu_result;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(NumIter - 1)) begin
          if (!f3_q[0]) begin
            state_d = StFixSign;
          end else begin
            state_d  = StDone;
            result_d = f3_q[1] ? acc_d : a_q;
          end
        end else begin
          state_d = StDivCmp;
        end
      end

      StFixSign: begin
        fix_val     = f3_q[1] ? acc_q : a_q;
        neg         = f3_q[1] ? sa_q : (sa_q ^ sb_q);
        alu_control = ALU_CTRL_SUB;
        alu_op_b    = fix_val;
        result_d    = neg ? alu_result : fix_val;
        state_d     = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule
